// File: rtl/uart_tx_scheduler.sv
// Sole writer of the UART TX FIFO: paces writes against tx_full and
// arbitrates single-byte events against periodic 6-byte position frames.
module uart_tx_scheduler #(
  parameter int FRAME_PERIOD = 40000,
  parameter int CNT_W        = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_full,
  input  logic [1:0] selected_player,
  input  logic [7:0] current_x,
  input  logic [7:0] current_y,
  input  logic       collision,
  input  logic       evt_req,
  input  logic [3:0] evt_code,
  output logic       evt_ack,
  output logic       wr_uart,
  output logic [7:0] w_data,
  output logic       busy,
  output logic [7:0] drop_cnt
);

  typedef enum logic [1:0] {IDLE, POS, EVT} state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] timer, timer_n;
  logic             tick;
  logic             pend, pend_n;
  logic [2:0]       idx, idx_n;
  logic [1:0]       s_sel, s_sel_n;
  logic [7:0]       s_x, s_x_n;
  logic [7:0]       s_y, s_y_n;
  logic             s_col, s_col_n;
  logic             wr_n, ack_n;
  logic [7:0]       data_n, drop_n;
  logic             take_pos;
  logic             sel_ok;
  logic [7:0]       pos_byte;

  assign tick   = (timer == CNT_W'(FRAME_PERIOD - 1));
  assign sel_ok = (s_sel == 2'b01) || (s_sel == 2'b11);
  assign busy   = (state != IDLE);

  // High nibbles beyond b0 are blanked when no player is selected
  always_comb begin
    pos_byte = 8'h00;
    case (idx)
      3'd0: pos_byte = {2'b00, s_sel, 4'h0};
      3'd1: pos_byte = {sel_ok ? s_x[3:0] : 4'h0, 4'h1};
      3'd2: pos_byte = {sel_ok ? s_x[7:4] : 4'h0, 4'h2};
      3'd3: pos_byte = {sel_ok ? s_y[7:4] : 4'h0, 4'h3};
      3'd4: pos_byte = {sel_ok ? s_y[3:0] : 4'h0, 4'h4};
      3'd5: pos_byte = {3'b000, sel_ok & s_col, 4'h5};
      default: pos_byte = 8'h00;
    endcase
  end

  always_comb begin
    state_n  = state;
    idx_n    = idx;
    s_sel_n  = s_sel;
    s_x_n    = s_x;
    s_y_n    = s_y;
    s_col_n  = s_col;
    wr_n     = 1'b0;
    ack_n    = 1'b0;
    data_n   = w_data;
    take_pos = 1'b0;
    if (!tx_full) begin
      case (state)
        IDLE: begin
          if (evt_req) begin
            state_n = EVT;
            idx_n   = 3'd0;
          end else if (pend) begin
            state_n  = POS;
            idx_n    = 3'd0;
            take_pos = 1'b1;
            s_sel_n  = selected_player;
            s_x_n    = current_x;
            s_y_n    = current_y;
            s_col_n  = collision;
          end
        end
        POS: begin
          if (idx == 3'd6) begin
            state_n = IDLE;
          end else if (!wr_uart) begin
            wr_n   = 1'b1;
            data_n = pos_byte;
            idx_n  = idx + 3'd1;
          end
        end
        EVT: begin
          if (idx == 3'd1) begin
            state_n = IDLE;
          end else if (!wr_uart) begin
            wr_n   = 1'b1;
            ack_n  = 1'b1;
            data_n = {evt_code, 4'hF};
            idx_n  = 3'd1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // A tick coinciding with frame start re-arms the request without a drop
  always_comb begin
    timer_n = tick ? '0 : timer + CNT_W'(1);
    pend_n  = tick ? 1'b1 : (take_pos ? 1'b0 : pend);
    drop_n  = drop_cnt;
    if (tick && pend && !take_pos && drop_cnt != 8'hFF)
      drop_n = drop_cnt + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      timer    <= '0;
      pend     <= 1'b0;
      idx      <= 3'd0;
      s_sel    <= 2'b00;
      s_x      <= 8'h00;
      s_y      <= 8'h00;
      s_col    <= 1'b0;
      wr_uart  <= 1'b0;
      evt_ack  <= 1'b0;
      w_data   <= 8'h00;
      drop_cnt <= 8'h00;
    end else begin
      state    <= state_n;
      timer    <= timer_n;
      pend     <= pend_n;
      idx      <= idx_n;
      s_sel    <= s_sel_n;
      s_x      <= s_x_n;
      s_y      <= s_y_n;
      s_col    <= s_col_n;
      wr_uart  <= wr_n;
      evt_ack  <= ack_n;
      w_data   <= data_n;
      drop_cnt <= drop_n;
    end
  end

endmodule
